// File: rtl/seg_display_decoder.sv
// ---------------------------------------------------------------------------
// seg_display_decoder
//
// Purpose:
//   Watches a multiplexed 7-segment display bus (segments + digit select)
//   and recovers the hex nibble, decimal point and blank/valid state shown
//   at each digit position. A sample is captured only after it has been
//   seen unchanged for STABLE_CYCLES consecutive registered cycles, which
//   rejects ghosting while the driver switches digits.
//
// Parameters:
//   W_DIGIT        number of multiplexed digit positions (2..8)
//   STABLE_CYCLES  identical consecutive samples needed before capture (1..255)
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   abcdefgh    in   segment bus, bit7=a .. bit1=g, bit0=h (decimal point)
//   digit       in   digit select, one-hot when addressing a position
//   value       out  decoded nibble per position, nibble i at [4i+3:4i]
//   dp          out  captured decimal point per position
//   valid       out  position holds a decoded, non-blank nibble
//   upd         out  one-cycle strobe when a position's outputs change
//   upd_index   out  position of the last change (held while upd=0)
//   upd_nibble  out  new nibble of the last change (held while upd=0)
//   err_cnt     out  saturating count of captured unknown patterns
//
// Configuration:
//   SEG_DISPLAY_DECODER_ERR_CNT_EN  when defined, builds the unknown-pattern
//                                   counter; otherwise err_cnt is tied to 0.
// ---------------------------------------------------------------------------
module seg_display_decoder #(
    parameter int W_DIGIT       = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             abcdefgh,
    input  logic [W_DIGIT-1:0]     digit,
    output logic [4*W_DIGIT-1:0]   value,
    output logic [W_DIGIT-1:0]     dp,
    output logic [W_DIGIT-1:0]     valid,
    output logic                   upd,
    output logic [2:0]             upd_index,
    output logic [3:0]             upd_nibble,
    output logic [7:0]             err_cnt
);

    localparam logic [7:0]         STABLE  = 8'(STABLE_CYCLES);
    localparam logic [W_DIGIT-1:0] DIG_ONE = W_DIGIT'(1);

    // input stage
    logic [7:0]         r_seg;
    logic [W_DIGIT-1:0] r_dig;

    // run qualification
    logic [7:0]         r_last_seg;
    logic [2:0]         r_last_idx;
    logic [7:0]         r_cnt;

    // captured display state
    logic [3:0]         r_nib [W_DIGIT];
    logic [W_DIGIT-1:0] r_dp;
    logic [W_DIGIT-1:0] r_valid;
    logic               r_upd;
    logic [2:0]         r_upd_index;
    logic [3:0]         r_upd_nibble;

    logic               w_onehot;
    logic [2:0]         w_index;
    logic               w_known;
    logic               w_blank;
    logic [3:0]         w_nib;
    logic               w_same;
    logic [7:0]         w_cnt_next;
    logic               w_capture;
    logic [3:0]         w_old_nib;
    logic               w_old_dp;
    logic               w_old_vld;
    logic [3:0]         w_new_nib;
    logic               w_new_dp;
    logic               w_new_vld;
    logic               w_change;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '0;
            r_dig <= '0;
        end else begin
            r_seg <= abcdefgh;
            r_dig <= digit;
        end
    end

    // exactly one select line high: non-zero and clearing the lowest set bit leaves nothing
    always_comb begin
        w_onehot = (r_dig != '0) && ((r_dig & (r_dig - DIG_ONE)) == '0);
        w_index  = '0;
        for (int i = 0; i < W_DIGIT; i++) begin
            if (r_dig[i]) begin
                w_index = 3'(i);
            end
        end
    end

    always_comb begin
        w_known = 1'b1;
        w_nib   = 4'h0;
        case (r_seg[7:1])
            7'b1111110: w_nib = 4'h0;
            7'b0110000: w_nib = 4'h1;
            7'b1101101: w_nib = 4'h2;
            7'b1111001: w_nib = 4'h3;
            7'b0110011: w_nib = 4'h4;
            7'b1011011: w_nib = 4'h5;
            7'b1011111: w_nib = 4'h6;
            7'b1110000: w_nib = 4'h7;
            7'b1111111: w_nib = 4'h8;
            7'b1111011: w_nib = 4'h9;
            7'b1110111: w_nib = 4'hA;
            7'b0011111: w_nib = 4'hB;
            7'b1001110: w_nib = 4'hC;
            7'b0111101: w_nib = 4'hD;
            7'b1001111: w_nib = 4'hE;
            7'b1000111: w_nib = 4'hF;
            default:    w_known = 1'b0;
        endcase
        w_blank = (r_seg[7:1] == 7'b0000000);
    end

    // r_cnt==0 marks "previous sample was not addressed", so a run can only
    // continue from a counted sample.
    always_comb begin
        w_same = (r_cnt != 8'd0) && (r_seg == r_last_seg) && (w_index == r_last_idx);
        if (!w_onehot) begin
            w_cnt_next = 8'd0;
        end else if (w_same) begin
            w_cnt_next = (r_cnt >= STABLE) ? STABLE : r_cnt + 8'd1;
        end else begin
            w_cnt_next = 8'd1;
        end
        // A saturated run that simply continues must not fire again; this also
        // covers STABLE_CYCLES=1 where every new sample lands directly on 1.
        w_capture = w_onehot && (w_cnt_next == STABLE) && !(w_same && (r_cnt == STABLE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_seg <= '0;
            r_last_idx <= '0;
            r_cnt      <= '0;
        end else begin
            r_last_seg <= r_seg;
            r_last_idx <= w_index;
            r_cnt      <= w_cnt_next;
        end
    end

    // blank keeps the old nibble but updates dp and drops valid; unknown keeps all
    always_comb begin
        w_old_nib = r_nib[w_index];
        w_old_dp  = r_dp[w_index];
        w_old_vld = r_valid[w_index];
        w_new_nib = w_known ? w_nib : w_old_nib;
        w_new_dp  = (w_known || w_blank) ? r_seg[0] : w_old_dp;
        if (w_known) begin
            w_new_vld = 1'b1;
        end else if (w_blank) begin
            w_new_vld = 1'b0;
        end else begin
            w_new_vld = w_old_vld;
        end
        w_change = w_capture && ((w_new_nib != w_old_nib) ||
                                 (w_new_dp  != w_old_dp)  ||
                                 (w_new_vld != w_old_vld));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < W_DIGIT; i++) begin
                r_nib[i] <= 4'h0;
            end
            r_dp         <= '0;
            r_valid      <= '0;
            r_upd        <= 1'b0;
            r_upd_index  <= '0;
            r_upd_nibble <= '0;
        end else begin
            if (w_capture) begin
                r_nib[w_index]   <= w_new_nib;
                r_dp[w_index]    <= w_new_dp;
                r_valid[w_index] <= w_new_vld;
            end
            r_upd <= w_change;
            if (w_change) begin
                r_upd_index  <= w_index;
                r_upd_nibble <= w_new_nib;
            end
        end
    end

`ifdef SEG_DISPLAY_DECODER_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic       w_unknown;

    assign w_unknown = !w_known && !w_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_capture && w_unknown && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

    always_comb begin
        value = '0;
        for (int i = 0; i < W_DIGIT; i++) begin
            value[4*i +: 4] = r_nib[i];
        end
    end

    assign dp         = r_dp;
    assign valid      = r_valid;
    assign upd        = r_upd;
    assign upd_index  = r_upd_index;
    assign upd_nibble = r_upd_nibble;

endmodule

// File: tb/tb_seg_display_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_display_decoder
//
// Directed stimulus for seg_display_decoder (W_DIGIT=8, STABLE_CYCLES=4).
// Every expected display change is queued when its stimulus is issued; a
// monitor pops and compares on each upd strobe. Extra direct checks cover
// strobe timing, reset and the error counter.
// ---------------------------------------------------------------------------
module tb_seg_display_decoder;

    localparam int W = 8;
`ifdef SEG_DISPLAY_DECODER_ERR_CNT_EN
    localparam int ERR_MAX = 255;
`else
    localparam int ERR_MAX = 0;
`endif

    logic           clk;
    logic           rst_n;
    logic [7:0]     abcdefgh;
    logic [W-1:0]   digit;
    logic [4*W-1:0] value;
    logic [W-1:0]   dp;
    logic [W-1:0]   valid;
    logic           upd;
    logic [2:0]     upd_index;
    logic [3:0]     upd_nibble;
    logic [7:0]     err_cnt;

    seg_display_decoder #(
        .W_DIGIT       (W),
        .STABLE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abcdefgh   (abcdefgh),
        .digit      (digit),
        .value      (value),
        .dp         (dp),
        .valid      (valid),
        .upd        (upd),
        .upd_index  (upd_index),
        .upd_nibble (upd_nibble),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic [3:0]  nib;
        logic [31:0] val;
        logic [7:0]  dpv;
        logic [7:0]  vld;
    } exp_t;

    exp_t        exp_q[$];
    int          checks;
    int          failures;
    logic [31:0] m_val;
    logic [7:0]  m_dp;
    logic [7:0]  m_vld;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_upd(input int idx, input logic [3:0] nib, input logic dpb, input logic vb);
        exp_t e;
        m_val[idx*4 +: 4] = nib;
        m_dp[idx]         = dpb;
        m_vld[idx]        = vb;
        e.idx = 3'(idx);
        e.nib = nib;
        e.val = m_val;
        e.dpv = m_dp;
        e.vld = m_vld;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [7:0] d, input logic [7:0] s, input int n);
        digit    = d;
        abcdefgh = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && upd) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_upd_index", {29'd0, upd_index}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("upd_index",  {29'd0, upd_index},  {29'd0, e.idx});
                chk("upd_nibble", {28'd0, upd_nibble}, {28'd0, e.nib});
                chk("upd_value",  value,               e.val);
                chk("upd_dp",     {24'd0, dp},         {24'd0, e.dpv});
                chk("upd_valid",  {24'd0, valid},      {24'd0, e.vld});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        m_val    = '0;
        m_dp     = '0;
        m_vld    = '0;
        rst_n    = 1'b0;
        digit    = '0;
        abcdefgh = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", value, 32'h0);
        chk("rst_valid", {24'd0, valid}, 32'h0);
        chk("rst_upd",   {31'd0, upd}, 32'h0);
        chk("rst_err",   {24'd0, err_cnt}, 32'h0);
        rst_n = 1'b1;
        drive(8'h00, 8'h00, 2);

        // position 2 shows '3': strobe exactly on the fifth edge
        expect_upd(2, 4'h3, 1'b0, 1'b1);
        drive(8'h04, 8'hF2, 4);
        chk("s1_no_upd_edge4", {31'd0, upd}, 32'h0);
        chk("s1_valid_edge4",  {24'd0, valid}, 32'h0);
        drive(8'h04, 8'hF2, 1);
        chk("s1_upd_edge5",    {31'd0, upd}, 32'h1);
        chk("s1_value_edge5",  value, 32'h0000_0300);
        drive(8'h04, 8'hF2, 1);
        chk("s1_upd_edge6",    {31'd0, upd}, 32'h0);
        chk("s1_hold_index",   {29'd0, upd_index}, 32'd2);
        chk("s1_hold_nibble",  {28'd0, upd_nibble}, 32'd3);
        drive(8'h04, 8'hF2, 4);

        // interrupted runs: 3 edges on pos 3, then 3 edges on pos 4
        drive(8'h08, 8'hF2, 3);
        drive(8'h10, 8'hF2, 3);
        drive(8'h00, 8'h00, 3);
        chk("s2_valid", {24'd0, valid}, {24'd0, m_vld});

        // multi-hot select never captures
        drive(8'h05, 8'h60, 10);
        drive(8'h00, 8'h00, 2);
        chk("s3_value", value, m_val);
        chk("s3_dp",    {24'd0, dp}, {24'd0, m_dp});
        chk("s3_err",   {24'd0, err_cnt}, 32'h0);

        // more positions, plus a recapture that changes nothing
        expect_upd(7, 4'hA, 1'b0, 1'b1);
        drive(8'h80, 8'hEE, 6);
        drive(8'h00, 8'h00, 1);
        drive(8'h80, 8'hEE, 6);
        drive(8'h00, 8'h00, 1);
        expect_upd(0, 4'h0, 1'b1, 1'b1);
        drive(8'h01, 8'hFD, 6);
        expect_upd(5, 4'hB, 1'b1, 1'b1);
        drive(8'h20, 8'h3F, 6);
        // blank with dp on position 2
        expect_upd(2, 4'h3, 1'b1, 1'b0);
        drive(8'h04, 8'h01, 6);
        drive(8'h00, 8'h00, 2);
        chk("s4_value", value, m_val);
        chk("s4_dp",    {24'd0, dp}, {24'd0, m_dp});
        chk("s4_valid", {24'd0, valid}, {24'd0, m_vld});

        // unknown pattern captured 300 times on position 0
        for (int n = 1; n <= 300; n++) begin
            drive(8'h00, 8'h00, 1);
            drive(8'h01, 8'h80, 4);
            drive(8'h00, 8'h00, 1);
            if (n == 1 || n == 254 || n == 255 || n == 300) begin
                chk($sformatf("s5_err_%0d", n), {24'd0, err_cnt},
                    32'((n < ERR_MAX) ? n : ERR_MAX));
            end
        end
        chk("s5_value", value, m_val);
        chk("s5_dp",    {24'd0, dp}, {24'd0, m_dp});
        chk("s5_valid", {24'd0, valid}, {24'd0, m_vld});

        // reset in the middle of a run on position 1
        drive(8'h02, 8'hB6, 2);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_value",  value, 32'h0);
        chk("s6_rst_dp",     {24'd0, dp}, 32'h0);
        chk("s6_rst_valid",  {24'd0, valid}, 32'h0);
        chk("s6_rst_index",  {29'd0, upd_index}, 32'h0);
        chk("s6_rst_nibble", {28'd0, upd_nibble}, 32'h0);
        chk("s6_rst_err",    {24'd0, err_cnt}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_val = '0;
        m_dp  = '0;
        m_vld = '0;
        expect_upd(1, 4'h5, 1'b0, 1'b1);
        drive(8'h02, 8'hB6, 4);
        chk("s6_no_upd_edge4", {31'd0, upd}, 32'h0);
        chk("s6_valid_edge4",  {24'd0, valid}, 32'h0);
        drive(8'h02, 8'hB6, 1);
        chk("s6_upd_edge5",    {31'd0, upd}, 32'h1);
        chk("s6_valid_edge5",  {24'd0, valid}, 32'h02);
        drive(8'h00, 8'h00, 3);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
